// File: rtl/way_alloc_pkg.sv
// Shared types and constants for the way allocation controller.
package way_alloc_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StGrant  = 2'd2
  } state_e;

  localparam int unsigned LfsrWidth = 8;

  // Feedback taps at bits 7, 3, 2 and 1.
  localparam logic [LfsrWidth-1:0] LfsrTaps = 8'h8E;

  // Wide enough for MaxTries up to 15.
  localparam int unsigned TryWidth = 4;

endpackage

// File: rtl/way_alloc_lfsr.sv
// 8-bit XNOR-feedback LFSR used to pick random victim candidates.
module way_alloc_lfsr
  import way_alloc_pkg::*;
#(
  parameter logic [LfsrWidth-1:0] Seed = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [LfsrWidth-1:0] state_o
);

  logic [LfsrWidth-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[LfsrWidth-2:0], ~(^(lfsr_q & LfsrTaps))};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/way_alloc_ctrl.sv
// Refill way allocator: invalid-first, then LFSR random victim with lowest-unlocked fallback.
// Define WAY_ALLOC_FREE_RUN_EN to let the LFSR advance in every state.
module way_alloc_ctrl
  import way_alloc_pkg::*;
#(
  parameter int unsigned          NumWays  = 8,
  parameter logic [LfsrWidth-1:0] Seed     = 8'h00,
  parameter int unsigned          MaxTries = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [NumWays-1:0]         valid_ways_i,
  input  logic [NumWays-1:0]         lock_ways_i,
  output logic                       gnt_valid_o,
  input  logic                       gnt_ready_i,
  output logic [NumWays-1:0]         gnt_way_oh_o,
  output logic [$clog2(NumWays)-1:0] gnt_way_bin_o,
  output logic                       gnt_evict_o,
  output logic                       gnt_err_o
);

  localparam int unsigned WayW = $clog2(NumWays);
  localparam logic [TryWidth-1:0] MaxTriesW = TryWidth'(MaxTries);

  state_e              state_q, state_d;
  logic [NumWays-1:0]  valid_q, valid_d;
  logic [NumWays-1:0]  lock_q, lock_d;
  logic [TryWidth-1:0] try_q, try_d;
  logic [WayW-1:0]     bin_q, bin_d;
  logic                evict_q, evict_d;
  logic                err_q, err_d;

  logic                 lfsr_en;
  logic [LfsrWidth-1:0] lfsr_state;
  logic [WayW-1:0]      cand;
  logic [NumWays-1:0]   in_free;
  logic [WayW-1:0]      in_free_idx;
  logic [WayW-1:0]      fb_idx;
  logic                 gnt_way_en;
  logic                 unused_lfsr;

`ifdef WAY_ALLOC_FREE_RUN_EN
  assign lfsr_en = 1'b1;
`else
  assign lfsr_en = (state_q == StSearch);
`endif

  way_alloc_lfsr #(
    .Seed(Seed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (lfsr_en),
    .state_o(lfsr_state)
  );

  assign cand        = lfsr_state[WayW-1:0];
  assign unused_lfsr = ^lfsr_state[LfsrWidth-1:WayW];

  // Free ways are judged on the live inputs so an immediate grant costs one cycle.
  assign in_free = ~valid_ways_i & ~lock_ways_i;

  // Lowest-index priority encoders; descending loop leaves the lowest match.
  always_comb begin
    in_free_idx = '0;
    fb_idx      = '0;
    for (int i = int'(NumWays) - 1; i >= 0; i--) begin
      if (in_free[i]) begin
        in_free_idx = WayW'(i);
      end
      if (!lock_q[i]) begin
        fb_idx = WayW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    lock_d  = lock_q;
    try_d   = try_q;
    bin_d   = bin_q;
    evict_d = evict_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          valid_d = valid_ways_i;
          lock_d  = lock_ways_i;
          try_d   = '0;
          if (|in_free) begin
            bin_d   = in_free_idx;
            evict_d = 1'b0;
            err_d   = 1'b0;
            state_d = StGrant;
          end else if (&lock_ways_i) begin
            bin_d   = '0;
            evict_d = 1'b0;
            err_d   = 1'b1;
            state_d = StGrant;
          end else begin
            state_d = StSearch;
          end
        end
      end

      StSearch: begin
        if (!lock_q[cand]) begin
          bin_d   = cand;
          evict_d = valid_q[cand];
          err_d   = 1'b0;
          state_d = StGrant;
        end else begin
          try_d = try_q + TryWidth'(1);
          if (try_d == MaxTriesW) begin
            bin_d   = fb_idx;
            evict_d = valid_q[fb_idx];
            err_d   = 1'b0;
            state_d = StGrant;
          end
        end
      end

      StGrant: begin
        if (gnt_ready_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      valid_q <= '0;
      lock_q  <= '0;
      try_q   <= '0;
      bin_q   <= '0;
      evict_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      try_q   <= try_d;
      bin_q   <= bin_d;
      evict_q <= evict_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign gnt_valid_o   = (state_q == StGrant);
  assign gnt_err_o     = gnt_valid_o & err_q;
  assign gnt_evict_o   = gnt_valid_o & evict_q;
  assign gnt_way_en    = gnt_valid_o & ~err_q;
  assign gnt_way_bin_o = gnt_way_en ? bin_q : '0;
  assign gnt_way_oh_o  = gnt_way_en ? (NumWays'(1) << bin_q) : '0;

endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Randomized self-checking bench for way_alloc_ctrl (NumWays=4, MaxTries 4 and 1).
module tb_way_alloc_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid   [2];
  logic       req_ready   [2];
  logic [3:0] valid_ways  [2];
  logic [3:0] lock_ways   [2];
  logic       gnt_valid   [2];
  logic       gnt_ready   [2];
  logic [3:0] gnt_way_oh  [2];
  logic [1:0] gnt_way_bin [2];
  logic       gnt_evict   [2];
  logic       gnt_err     [2];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] mlfsr [2];
  int max_tries [2];

  way_alloc_ctrl #(.NumWays(4), .Seed(8'h00), .MaxTries(4)) u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[0]),
    .req_ready_o  (req_ready[0]),
    .valid_ways_i (valid_ways[0]),
    .lock_ways_i  (lock_ways[0]),
    .gnt_valid_o  (gnt_valid[0]),
    .gnt_ready_i  (gnt_ready[0]),
    .gnt_way_oh_o (gnt_way_oh[0]),
    .gnt_way_bin_o(gnt_way_bin[0]),
    .gnt_evict_o  (gnt_evict[0]),
    .gnt_err_o    (gnt_err[0])
  );

  way_alloc_ctrl #(.NumWays(4), .Seed(8'h00), .MaxTries(1)) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid[1]),
    .req_ready_o  (req_ready[1]),
    .valid_ways_i (valid_ways[1]),
    .lock_ways_i  (lock_ways[1]),
    .gnt_valid_o  (gnt_valid[1]),
    .gnt_ready_i  (gnt_ready[1]),
    .gnt_way_oh_o (gnt_way_oh[1]),
    .gnt_way_bin_o(gnt_way_bin[1]),
    .gnt_evict_o  (gnt_evict[1]),
    .gnt_err_o    (gnt_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] m);
    return {m[6:0], ~(m[7] ^ m[3] ^ m[2] ^ m[1])};
  endfunction

  // Transaction-level reference: latency in cycles after accept and the resulting grant.
  task automatic model_txn(input int s, input logic [3:0] v, input logic [3:0] l,
                           output int lat, output int way, output bit ev, output bit er);
    logic [3:0] free;
    int tries;
    int c;
    bit done;
    free = ~v & ~l;
    lat = 1;
    way = 0;
    ev = 1'b0;
    er = 1'b0;
    if (free != 4'd0) begin
      for (int i = 3; i >= 0; i--) if (free[i]) way = i;
    end else if (l == 4'hF) begin
      er = 1'b1;
    end else begin
      tries = 0;
      done = 1'b0;
      ev = 1'b1;
      while (!done) begin
        lat++;
        c = int'(mlfsr[s][1:0]);
        mlfsr[s] = lfsr_next(mlfsr[s]);
        if (!l[c]) begin
          way = c;
          done = 1'b1;
        end else begin
          tries++;
          if (tries == max_tries[s]) begin
            for (int i = 3; i >= 0; i--) if (!l[i]) way = i;
            done = 1'b1;
          end
        end
      end
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic do_txn(input int s, input logic [3:0] v, input logic [3:0] l, input int hold,
                        input int exp_lat, input int exp_way, input bit exp_ev, input bit exp_er);
    int lat;
    logic [3:0] exp_oh;
    exp_oh = exp_er ? 4'd0 : 4'(1 << exp_way);
    check("req_ready_idle", req_ready[s], 1);
    req_valid[s] = 1'b1;
    valid_ways[s] = v;
    lock_ways[s] = l;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    valid_ways[s] = 4'($urandom);
    lock_ways[s] = 4'($urandom);
    lat = 1;
    while (!gnt_valid[s] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("grant_latency", lat, exp_lat);
    for (int h = 0; h <= hold; h++) begin
      check("gnt_valid", gnt_valid[s], 1);
      check("gnt_way_bin", gnt_way_bin[s], exp_er ? 0 : exp_way);
      check("gnt_way_oh", gnt_way_oh[s], exp_oh);
      check("gnt_evict", gnt_evict[s], exp_ev);
      check("gnt_err", gnt_err[s], exp_er);
      check("req_ready_grant", req_ready[s], 0);
      if (h < hold) begin
        valid_ways[s] = 4'($urandom);
        lock_ways[s] = 4'($urandom);
        req_valid[s] = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    req_valid[s] = 1'b0;
    gnt_ready[s] = 1'b1;
    @(posedge clk); #1;
    gnt_ready[s] = 1'b0;
    check("gnt_valid_after_ack", gnt_valid[s], 0);
    check("req_ready_after_ack", req_ready[s], 1);
  endtask

  task automatic directed(input int s, input logic [3:0] v, input logic [3:0] l, input int hold,
                          input int exp_lat, input int exp_way, input bit exp_ev, input bit exp_er);
    int lat, way;
    bit ev, er;
    model_txn(s, v, l, lat, way, ev, er);
    do_txn(s, v, l, hold, exp_lat, exp_way, exp_ev, exp_er);
  endtask

  initial begin
    int lat, way, s, pat, hold;
    bit ev, er;
    logic [3:0] v, l;
    max_tries[0] = 4;
    max_tries[1] = 1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      valid_ways[i] = 4'd0;
      lock_ways[i] = 4'd0;
      gnt_ready[i] = 1'b0;
      mlfsr[i] = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_gnt_valid", gnt_valid[i], 0);
      check("rst_gnt_err", gnt_err[i], 0);
      check("rst_gnt_evict", gnt_evict[i], 0);
      check("rst_gnt_oh", gnt_way_oh[i], 0);
      check("rst_gnt_bin", gnt_way_bin[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready_a", req_ready[0], 1);
    check("rst_req_ready_b", req_ready[1], 1);

    // Invalid way 2 is free: immediate grant.
    directed(0, 4'b1011, 4'b0000, 0, 1, 2, 1'b0, 1'b0);
    // All valid, Seed 0: one SEARCH cycle picks way 0.
    directed(0, 4'b1111, 4'b0000, 0, 2, 0, 1'b1, 1'b0);
    // All locked: error grant.
    directed(0, 4'b1111, 4'b1111, 2, 1, 0, 1'b0, 1'b1);
    // MaxTries=1, candidate 0 locked: fallback to way 3, held 5 cycles.
    directed(1, 4'b1111, 4'b0111, 5, 2, 3, 1'b1, 1'b0);

    // Reset pulse while dut_a is searching (LFSR=1: candidate 1 locked first).
    req_valid[0] = 1'b1;
    valid_ways[0] = 4'b1111;
    lock_ways[0] = 4'b0111;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("search_no_grant", gnt_valid[0], 0);
    check("search_not_ready", req_ready[0], 0);
    rst_n = 1'b0;
    #3;
    check("rst_abort_gnt_valid", gnt_valid[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mlfsr[0] = 8'h00;
    mlfsr[1] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      check("post_rst_gnt_valid", gnt_valid[0], 0);
      check("post_rst_req_ready", req_ready[0], 1);
      @(posedge clk); #1;
    end
    // LFSR back at Seed: first search candidate is way 0.
    directed(0, 4'b1111, 4'b0000, 0, 2, 0, 1'b1, 1'b0);

    for (int k = 0; k < 160; k++) begin
      s = k % 2;
      pat = $urandom_range(0, 3);
      v = 4'($urandom);
      l = 4'($urandom);
      if (pat != 0) v = 4'hF;
      if (pat == 2) l = 4'($urandom) & 4'($urandom);
      if (pat == 3 && ($urandom_range(0, 3) == 0)) l = 4'hF;
      hold = $urandom_range(0, 3);
      model_txn(s, v, l, lat, way, ev, er);
      do_txn(s, v, l, hold, lat, way, ev, er);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/way_alloc_ctrl.md
WAY_ALLOC_CTRL -- requirements
Module: way_alloc_ctrl

Interface
REQ-001 SHALL have parameter NumWays, default 8, number of cache ways; legal values 2, 4, 8.
REQ-002 SHALL have parameter Seed, default 8'h00, LFSR reset value.
REQ-003 SHALL have parameter MaxTries, default 4, random attempts before fallback; legal range 1..15.
REQ-004 SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  in  1  refill allocation request.
REQ-007 SHALL have port req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-008 SHALL have port valid_ways_i  in  NumWays  per-way valid bits of the addressed set.
REQ-009 SHALL have port lock_ways_i  in  NumWays  per-way lock bits; a locked way is never granted.
REQ-010 SHALL have port gnt_valid_o  out  1  grant available.
REQ-011 SHALL have port gnt_ready_i  in  1  grant consumed when high with gnt_valid_o.
REQ-012 SHALL have port gnt_way_oh_o  out  NumWays  granted way, one-hot.
REQ-013 SHALL have port gnt_way_bin_o  out  $clog2(NumWays)  granted way, binary.
REQ-014 SHALL have port gnt_evict_o  out  1  granted way was valid at capture.
REQ-015 SHALL have port gnt_err_o  out  1  all ways locked; no way granted.

Function
REQ-016 SHALL implement FSM states IDLE, SEARCH, GRANT.
REQ-017 SHALL drive req_ready_o=1 only in IDLE.
REQ-018 On accept in IDLE, SHALL register valid_ways_i and lock_ways_i; later input changes are ignored until the next accept.
REQ-019 If any captured way is invalid and unlocked, SHALL select the lowest such index, evict=0, enter GRANT (gnt_valid_o one cycle after accept).
REQ-020 Else if all captured ways are locked, SHALL enter GRANT with gnt_err_o=1, way outputs all zero, evict=0.
REQ-021 Else SHALL enter SEARCH and clear the try counter.
REQ-022 In SEARCH, candidate SHALL be lfsr[$clog2(NumWays)-1:0]; if unlocked, select it, evict=1, enter GRANT.
REQ-023 In SEARCH, LFSR SHALL advance every cycle; try counter increments on each locked candidate.
REQ-024 When the try counter reaches MaxTries with no hit, SHALL select the lowest-index unlocked way, evict=1, enter GRANT.
REQ-025 LFSR SHALL be 8 bits, next = {q[6:0], ~(q[7]^q[3]^q[2]^q[1])}.
REQ-026 In GRANT, all gnt_* outputs SHALL stay stable until gnt_ready_i=1, then return to IDLE; back-to-back accept is earliest the following cycle.
REQ-027 gnt_way_oh_o SHALL equal the one-hot decode of gnt_way_bin_o whenever gnt_valid_o=1 and gnt_err_o=0.

Reset
REQ-028 On rst_ni low, SHALL go to IDLE, LFSR=Seed, try counter=0, registered vectors=0, gnt_valid_o=0, gnt_err_o=0, gnt_evict_o=0, way outputs=0, req_ready_o=1 after release.
REQ-029 Reset asserted in SEARCH or GRANT SHALL abort the request without any grant.

Configuration
REQ-030 Macro WAY_ALLOC_FREE_RUN_EN defined: LFSR SHALL advance every cycle in all states.
REQ-031 Macro undefined: LFSR SHALL advance only in SEARCH and hold otherwise.

Structure
REQ-032 Package way_alloc_pkg SHALL hold the FSM state enum, LFSR width (8), and tap mask constant.
REQ-033 LFSR SHALL be a sub-module way_alloc_lfsr (en_i, state out); the FSM, try counter and priority encoders stay in way_alloc_ctrl.

Verification
REQ-034 NumWays=4, valid=4'b1011, lock=0, accept at t -> gnt_valid_o at t+1, way_bin=2, oh=4'b0100, evict=0.
REQ-035 NumWays=4, valid=4'b1111, lock=0, Seed=8'h00, macro off -> SEARCH one cycle, grant way_bin=0, evict=1, gnt_valid_o at t+2.
REQ-036 NumWays=4, valid=4'b1111, lock=4'b1111 -> gnt_valid_o at t+1, gnt_err_o=1, oh=0.
REQ-037 NumWays=4, valid=4'b1111, lock=4'b0111, Seed=8'h00, MaxTries=1 -> candidate 0 locked, fallback grants way 3 at t+2, evict=1.
REQ-038 Grant held with gnt_ready_i=0 for 5 cycles while valid/lock inputs toggle -> outputs unchanged, req_ready_o=0; gnt_ready_i=1 -> IDLE next cycle.
REQ-039 rst_ni pulsed low during SEARCH -> no gnt_valid_o, LFSR reads Seed, req_ready_o=1 after release.
